// File: rtl/ramb16_s4_port_arbiter_if.sv
// One requester channel of the port-A arbiter: request handshake plus the
// tagged read-response path back to that requester.
interface ramb16_s4_port_arbiter_if #(
  parameter int ADDR_BITS = 12,
  parameter int DATA_BITS = 4
);
  logic                 valid;
  logic                 ready;
  logic                 we;
  logic [ADDR_BITS-1:0] addr;
  logic [DATA_BITS-1:0] data;
  logic                 rsp_valid;
  logic [DATA_BITS-1:0] rsp_data;

  // Requester side
  modport master (
    output valid, we, addr, data,
    input  ready, rsp_valid, rsp_data
  );

  // Arbiter side
  modport slave (
    input  valid, we, addr, data,
    output ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/ramb16_s4_port_arbiter.sv
// Shares port A of a 4096x4 dual-port block RAM between two requesters.
// Round-robin grant, one access per cycle; read data is routed back to the
// requester that issued it. An optional sweep zero-fills the array after
// reset before any request is accepted.
module ramb16_s4_port_arbiter #(
  parameter int ADDR_BITS      = 12,
  parameter int DATA_BITS      = 4,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                 CLK,
  input  logic                 reset,
  ramb16_s4_port_arbiter_if.slave port0,
  ramb16_s4_port_arbiter_if.slave port1,
  output logic                 ram_en,
  output logic                 ram_we,
  output logic                 ram_ssr,
  output logic [ADDR_BITS-1:0] ram_addr,
  output logic [DATA_BITS-1:0] ram_di,
  input  logic [DATA_BITS-1:0] ram_do,
  output logic                 clear_done
);

  localparam int DEPTH = 1 << ADDR_BITS;
  // One extra bit so the counter never wraps while reaching DEPTH-1.
  localparam logic [ADDR_BITS:0] CLR_LAST = (ADDR_BITS+1)'(DEPTH - 1);

  localparam logic [0:0] S_CLEAR = 1'b0;
  localparam logic [0:0] S_RUN   = 1'b1;
  localparam logic [0:0] S_AFTER_RESET = CLEAR_ON_RESET ? S_CLEAR : S_RUN;

  logic [0:0]           state;
  logic [ADDR_BITS:0]   clr_cnt;
  logic                 rr_ptr;     // requester favoured when both are valid
  logic                 pend0;      // read accepted last cycle for requester 0
  logic                 pend1;
  logic [DATA_BITS-1:0] hold0;      // last data delivered to requester 0
  logic [DATA_BITS-1:0] hold1;
  logic                 run;
  logic                 grant0;
  logic                 grant1;

  // Round-robin grant; nothing is granted while clearing or in reset.
  always_comb begin
    run    = (state == S_RUN) && !reset;
    grant0 = run && port0.valid && (!port1.valid || !rr_ptr);
    grant1 = run && port1.valid && (!port0.valid ||  rr_ptr);
  end

  // RAM port A mux: clear sweep, else the granted request, else idle.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned
    // (an unassigned path would infer a latch).
    ram_en   = 1'b0;
    ram_we   = 1'b0;
    ram_addr = '0;
    ram_di   = '0;
    if (!reset && state == S_CLEAR) begin
      ram_en   = 1'b1;
      ram_we   = 1'b1;
      ram_addr = clr_cnt[ADDR_BITS-1:0];
    end else if (grant0) begin
      ram_en   = 1'b1;
      ram_we   = port0.we;
      ram_addr = port0.addr;
      ram_di   = port0.data;
    end else if (grant1) begin
      ram_en   = 1'b1;
      ram_we   = port1.we;
      ram_addr = port1.addr;
      ram_di   = port1.data;
    end
  end

  assign ram_ssr    = 1'b0;
  assign clear_done = run;

  assign port0.ready = grant0;
  assign port1.ready = grant1;

  // Responses are forced low during reset so an in-flight read is dropped.
  assign port0.rsp_valid = pend0 && !reset;
  assign port1.rsp_valid = pend1 && !reset;
  assign port0.rsp_data  = reset ? '0 : (pend0 ? ram_do : hold0);
  assign port1.rsp_data  = reset ? '0 : (pend1 ? ram_do : hold1);

  // Clear sequencer: sweep every address once, then stay in RUN.
  always_ff @(posedge CLK) begin
    // NOTE: registered state uses non-blocking assignments so all flops
    // update together at the edge regardless of statement order.
    if (reset) begin
      state   <= S_AFTER_RESET;
      clr_cnt <= '0;
    end else if (state == S_CLEAR) begin
      clr_cnt <= clr_cnt + 1'b1;
      if (clr_cnt == CLR_LAST) begin
        state <= S_RUN;
      end
    end
  end

  // Round-robin pointer: favour the other requester after each grant.
  always_ff @(posedge CLK) begin
    if (reset) begin
      rr_ptr <= 1'b0;
    end else if (grant0) begin
      rr_ptr <= 1'b1;
    end else if (grant1) begin
      rr_ptr <= 1'b0;
    end
  end

  // Read tags and held response data; RAM output is valid one cycle later.
  always_ff @(posedge CLK) begin
    if (reset) begin
      pend0 <= 1'b0;
      pend1 <= 1'b0;
      hold0 <= '0;
      hold1 <= '0;
    end else begin
      pend0 <= grant0 && !port0.we;
      pend1 <= grant1 && !port1.we;
      if (pend0) hold0 <= ram_do;
      if (pend1) hold1 <= ram_do;
    end
  end

endmodule

// File: tb/tb_ramb16_s4_port_arbiter.sv
// Bench for the port-A arbiter: behavioural write-first RAM, directed
// stimulus, and a negedge monitor that checks grants and responses
// against queues filled by the stimulus.
module tb_ramb16_s4_port_arbiter;

  localparam int AW    = 12;
  localparam int DW    = 4;
  localparam int DEPTH = 1 << AW;

  logic          CLK = 1'b0;
  logic          reset = 1'b1;
  logic          ram_en, ram_we, ram_ssr, clear_done;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_di;
  logic [DW-1:0] ram_do = '0;
  logic [DW-1:0] mem [DEPTH];

  int checks = 0;
  int errors = 0;

  int            exp_grant [$];
  logic [DW-1:0] exp_d0 [$];
  logic [DW-1:0] exp_d1 [$];

  ramb16_s4_port_arbiter_if #(.ADDR_BITS(AW), .DATA_BITS(DW)) p0 ();
  ramb16_s4_port_arbiter_if #(.ADDR_BITS(AW), .DATA_BITS(DW)) p1 ();

  ramb16_s4_port_arbiter #(
    .ADDR_BITS(AW), .DATA_BITS(DW), .CLEAR_ON_RESET(1'b1)
  ) dut (
    .CLK(CLK), .reset(reset), .port0(p0), .port1(p1),
    .ram_en(ram_en), .ram_we(ram_we), .ram_ssr(ram_ssr),
    .ram_addr(ram_addr), .ram_di(ram_di), .ram_do(ram_do),
    .clear_done(clear_done)
  );

  always #5 CLK = ~CLK;

  // Port-A RAM model: write-first, registered output. Non-zero power-up
  // contents make the clear sweep observable.
  initial for (int i = 0; i < DEPTH; i++) mem[i] = 4'hF;
  always @(posedge CLK) begin
    if (ram_en) begin
      if (ram_we) begin
        mem[ram_addr] <= ram_di;
        ram_do        <= ram_di;
      end else begin
        ram_do <= mem[ram_addr];
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got unexpected event, expected none at %0t", name, $time);
  endtask

  // Monitor: grants and responses, sampled on the falling edge.
  logic pend_tb0 = 1'b0;
  logic pend_tb1 = 1'b0;
  always @(negedge CLK) begin
    logic exp_v0, exp_v1;
    if (p0.ready || p1.ready) begin
      check("one_ready", 32'(p0.ready & p1.ready), 0);
      check("ready_has_valid", 32'((p0.ready & ~p0.valid) | (p1.ready & ~p1.valid)), 0);
      check("ready_in_run", 32'(clear_done), 1);
      if (exp_grant.size() == 0) fail("grant_unexpected");
      else check("grant", 32'(p1.ready), exp_grant.pop_front());
    end
    exp_v0 = pend_tb0 && !reset;
    exp_v1 = pend_tb1 && !reset;
    if (p0.rsp_valid || exp_v0) check("rsp0_valid", 32'(p0.rsp_valid), 32'(exp_v0));
    if (p1.rsp_valid || exp_v1) check("rsp1_valid", 32'(p1.rsp_valid), 32'(exp_v1));
    if (p0.rsp_valid) begin
      if (exp_d0.size() == 0) fail("rsp0_unexpected");
      else check("rsp0_data", 32'(p0.rsp_data), 32'(exp_d0.pop_front()));
    end
    if (p1.rsp_valid) begin
      if (exp_d1.size() == 0) fail("rsp1_unexpected");
      else check("rsp1_data", 32'(p1.rsp_data), 32'(exp_d1.pop_front()));
    end
    pend_tb0 = p0.ready && p0.valid && !p0.we;
    pend_tb1 = p1.ready && p1.valid && !p1.we;
  end

  task automatic set_req(input int p, input logic v, input logic we,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (p == 0) begin
      p0.valid = v; p0.we = we; p0.addr = a; p0.data = d;
    end else begin
      p1.valid = v; p1.we = we; p1.addr = a; p1.data = d;
    end
  endtask

  // Waits (bounded) for the handshake; returns at posedge+1 after it.
  task automatic wait_ready(input int p, input int limit);
    int n = 0;
    forever begin
      @(negedge CLK);
      if ((p == 0) ? p0.ready : p1.ready) break;
      n++;
      if (n >= limit) begin
        check("ready_timeout", 0, 1);
        break;
      end
    end
    @(posedge CLK);
    #1;
  endtask

  // One access; called and returning at posedge+1, so calls chain back to back.
  task automatic access(input int p, input logic we, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic [DW-1:0] e);
    exp_grant.push_back(p);
    if (!we) begin
      if (p == 0) exp_d0.push_back(e);
      else        exp_d1.push_back(e);
    end
    set_req(p, 1'b1, we, a, d);
    wait_ready(p, 50);
    set_req(p, 1'b0, 1'b0, '0, '0);
  endtask

  // Called at posedge+1 right after reset is released.
  task automatic clear_timing(input string tag);
    int n = 0;
    #1;
    check({tag, "_addr0"}, 32'(ram_addr), 0);
    check({tag, "_en"}, 32'({ram_en, ram_we}), 3);
    check({tag, "_not_done"}, 32'(clear_done), 0);
    while (!clear_done && n < 5000) begin
      @(posedge CLK);
      #1;
      n++;
    end
    check({tag, "_cycles"}, n, DEPTH);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int i0, i1;
    logic r0, r1;
    set_req(0, 1'b1, 1'b0, 12'h123, '0);   // valid during reset must not be accepted
    set_req(1, 1'b0, 1'b0, '0, '0);

    // 1: reset state, clear timing, cleared contents
    repeat (3) @(posedge CLK);
    #1;
    check("rst_outputs", 32'({ram_en, ram_we, ram_ssr, clear_done, p0.ready,
                              p0.rsp_valid, p1.rsp_valid}), 0);
    set_req(0, 1'b0, 1'b0, '0, '0);
    reset = 1'b0;
    clear_timing("clr1");
    access(0, 1'b0, 12'h000, '0, 4'h0);
    access(0, 1'b0, 12'h7FF, '0, 4'h0);
    access(1, 1'b0, 12'hFFF, '0, 4'h0);

    // 2: write then read at top address; data holds after the response
    access(0, 1'b1, 12'hFFF, 4'hA, '0);
    access(0, 1'b0, 12'hFFF, '0, 4'hA);
    @(posedge CLK);
    #1;
    check("rsp0_hold", 32'({p0.rsp_valid, p0.rsp_data}), 32'h0A);

    // 3: preload, ending on requester 1 so rr_ptr returns to 0
    for (int k = 0; k < 8; k++) access(k % 2, 1'b1, 12'(32 + k), 4'(k + 1), '0);
    for (int k = 0; k < 4; k++) begin
      exp_grant.push_back(0);
      exp_grant.push_back(1);
      exp_d0.push_back(4'(2 * k + 1));
      exp_d1.push_back(4'(2 * k + 2));
    end
    i0 = 0;
    i1 = 0;
    set_req(0, 1'b1, 1'b0, 12'h020, '0);
    set_req(1, 1'b1, 1'b0, 12'h021, '0);
    for (int c = 0; c < 8; c++) begin
      @(negedge CLK);
      r0 = p0.ready;
      r1 = p1.ready;
      @(posedge CLK);
      #1;
      if (r0) i0++;
      if (r1) i1++;
      if (i0 < 4) set_req(0, 1'b1, 1'b0, 12'(32 + 2 * i0), '0);
      else        set_req(0, 1'b0, 1'b0, '0, '0);
      if (i1 < 4) set_req(1, 1'b1, 1'b0, 12'(33 + 2 * i1), '0);
      else        set_req(1, 1'b0, 1'b0, '0, '0);
    end
    set_req(0, 1'b0, 1'b0, '0, '0);
    set_req(1, 1'b0, 1'b0, '0, '0);

    // 4: write by 1 then immediate read by 0 of the same address
    access(1, 1'b1, 12'h010, 4'h5, '0);
    access(0, 1'b0, 12'h010, '0, 4'h5);
    repeat (2) @(posedge CLK);
    #1;

    // 6: reset the cycle after a read handshake drops the response;
    //    a request held through reset is only taken after the clear
    exp_grant.push_back(0);
    set_req(0, 1'b1, 1'b0, 12'h010, '0);
    wait_ready(0, 50);
    reset = 1'b1;
    exp_grant.push_back(0);
    exp_d0.push_back(4'h0);
    set_req(0, 1'b1, 1'b0, 12'h7FF, '0);
    repeat (2) @(posedge CLK);
    #1;
    reset = 1'b0;
    wait_ready(0, 5000);
    set_req(0, 1'b0, 1'b0, '0, '0);

    // 5: reset mid-sweep at address 0x100 restarts the sweep
    access(0, 1'b1, 12'hFFF, 4'hC, '0);
    reset = 1'b1;
    @(posedge CLK);
    #1;
    reset = 1'b0;
    for (int n = 0; n < 5000; n++) begin
      @(posedge CLK);
      #1;
      if (ram_en && ram_addr == 12'h100) break;
    end
    check("clr2_reached_100", 32'(ram_addr), 32'h100);
    reset = 1'b1;
    @(posedge CLK);
    #1;
    reset = 1'b0;
    clear_timing("clr2");
    access(0, 1'b0, 12'hFFF, '0, 4'h0);
    access(1, 1'b0, 12'h100, '0, 4'h0);

    repeat (4) @(posedge CLK);
    #1;
    check("grant_queue_empty", exp_grant.size(), 0);
    check("rsp0_queue_empty", exp_d0.size(), 0);
    check("rsp1_queue_empty", exp_d1.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
